// File: rtl/motor_shutdown_ctrl.sv
// Motor enable/duty owner: ramps duty to zero on watchdog trip or stop, latches fault, restarts only on operator re-arm.
// Outputs registered (duty tracks speed_cmd one cycle late); optional FAULT_COUNT_EN adds a saturating fault_cnt output.
module motor_shutdown_ctrl #(
  parameter int DUTY_W     = 8,
  parameter int RAMP_STEP  = 8,
  parameter int RAMP_DIV   = 4,
  parameter int GRACE      = 200,
  parameter int REARM_HOLD = 16
) (
  input  logic              clk_1khz,
  input  logic              rst,
  input  logic              wd_shtdwn,
  input  logic              run_req,
  input  logic              arm_req,
  input  logic [DUTY_W-1:0] speed_cmd,
  output logic [DUTY_W-1:0] duty_out,
  output logic              motor_en,
  output logic              fault,
  output logic [1:0]        state_out
`ifdef FAULT_COUNT_EN
  ,
  output logic [7:0]        fault_cnt
`endif
);

  localparam int GW = $clog2(GRACE + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int HW = $clog2(REARM_HOLD + 1);
  localparam logic [GW-1:0]     GRACE_V  = GW'(GRACE);
  localparam logic [RW-1:0]     DIV_LAST = RW'(RAMP_DIV - 1);
  localparam logic [HW-1:0]     HOLD_V   = HW'(REARM_HOLD);
  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    RAMP_DOWN = 2'b10,
    FAULT     = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [DUTY_W-1:0] duty_n;
  logic              en_n, fault_n;
  logic [GW-1:0]     grace_cnt, grace_n;
  logic [RW-1:0]     ramp_cnt, ramp_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic              arm_q, arm_rise, wd_qual, ramp_done;

  assign arm_rise  = arm_req & ~arm_q;
  // grace_cnt freezes outside RUN, so a normal stop before grace expiry keeps ignoring the watchdog
  assign wd_qual   = wd_shtdwn & (grace_cnt == GRACE_V);
  assign state_out = state;

  always_comb begin
    state_n   = state;
    duty_n    = duty_out;
    en_n      = motor_en;
    fault_n   = fault;
    grace_n   = grace_cnt;
    ramp_n    = ramp_cnt;
    hold_n    = hold_cnt;
    ramp_done = 1'b0;
    case (state)
      IDLE: begin
        duty_n = '0;
        en_n   = 1'b0;
        if (run_req) begin
          state_n = RUN;
          en_n    = 1'b1;
          grace_n = '0;
        end
      end
      RUN: begin
        duty_n = speed_cmd;
        if (grace_cnt != GRACE_V) grace_n = grace_cnt + 1'b1;
        if (wd_qual || !run_req) begin
          state_n = RAMP_DOWN;
          ramp_n  = '0;
          if (wd_qual) fault_n = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (wd_qual) fault_n = 1'b1;
        if (duty_out == '0) begin
          ramp_done = 1'b1;
        end else if (ramp_cnt == DIV_LAST) begin
          ramp_n    = '0;
          duty_n    = (duty_out > STEP_V) ? duty_out - STEP_V : '0;
          ramp_done = (duty_n == '0);
        end else begin
          ramp_n = ramp_cnt + 1'b1;
        end
        if (ramp_done) begin
          en_n    = 1'b0;
          hold_n  = '0;
          state_n = fault_n ? FAULT : IDLE;
        end
      end
      FAULT: begin
        duty_n  = '0;
        en_n    = 1'b0;
        fault_n = 1'b1;
        if (run_req) hold_n = '0;
        else if (hold_cnt != HOLD_V) hold_n = hold_cnt + 1'b1;
        if (arm_rise && !run_req && hold_cnt == HOLD_V) begin
          state_n = IDLE;
          fault_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state     <= IDLE;
      duty_out  <= '0;
      motor_en  <= 1'b0;
      fault     <= 1'b0;
      grace_cnt <= '0;
      ramp_cnt  <= '0;
      hold_cnt  <= '0;
      arm_q     <= 1'b0;
    end else begin
      state     <= state_n;
      duty_out  <= duty_n;
      motor_en  <= en_n;
      fault     <= fault_n;
      grace_cnt <= grace_n;
      ramp_cnt  <= ramp_n;
      hold_cnt  <= hold_n;
      arm_q     <= arm_req;
    end
  end

`ifdef FAULT_COUNT_EN
  always_ff @(posedge clk_1khz) begin
    if (rst) fault_cnt <= '0;
    else if (!fault && fault_n && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_motor_shutdown_ctrl.sv
// Bench for motor_shutdown_ctrl: directed literal checks plus randomized segments against a timing-arithmetic model.
module tb_motor_shutdown_ctrl;
  localparam int DUTY_W     = 8;
  localparam int RAMP_STEP  = 8;
  localparam int RAMP_DIV   = 4;
  localparam int GRACE      = 200;
  localparam int REARM_HOLD = 16;

  logic              clk_1khz = 1'b0;
  logic              rst = 1'b1;
  logic              wd_shtdwn = 1'b0;
  logic              run_req = 1'b0;
  logic              arm_req = 1'b0;
  logic [DUTY_W-1:0] speed_cmd = '0;
  logic [DUTY_W-1:0] duty_out;
  logic              motor_en;
  logic              fault;
  logic [1:0]        state_out;
`ifdef FAULT_COUNT_EN
  logic [7:0]        fault_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  motor_shutdown_ctrl #(
    .DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV),
    .GRACE(GRACE), .REARM_HOLD(REARM_HOLD)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .wd_shtdwn(wd_shtdwn),
    .run_req  (run_req),
    .arm_req  (arm_req),
    .speed_cmd(speed_cmd),
    .duty_out (duty_out),
    .motor_en (motor_en),
    .fault    (fault),
    .state_out(state_out)
`ifdef FAULT_COUNT_EN
    ,
    .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk_1khz = ~clk_1khz;

  // Reference model: timing expressed as edge numbers since mode entry
  int m_state = 0, m_duty = 0, m_en = 0, m_fault = 0, m_fcnt = 0;
  int t = 0, t_run = 0, t_ramp = 0, t_clr = 0, d0 = 0;
  bit arm_prev = 1'b0;

  always @(posedge clk_1khz) begin
    int k, nd, hold, f_before;
    bit qual, arm_rise;
    t++;
    if (rst) begin
      m_state = 0; m_duty = 0; m_en = 0; m_fault = 0; m_fcnt = 0; arm_prev = 1'b0;
    end else begin
      f_before = m_fault;
      arm_rise = arm_req && !arm_prev;
      case (m_state)
        0: begin
          m_duty = 0; m_en = 0;
          if (run_req) begin m_state = 1; m_en = 1; t_run = t; end
        end
        1: begin
          qual = wd_shtdwn && (t - 1 - t_run >= GRACE);
          m_duty = int'(speed_cmd);
          if (qual || !run_req) begin
            m_state = 2; t_ramp = t; d0 = int'(speed_cmd);
            if (qual) m_fault = 1;
          end
        end
        2: begin
          if (wd_shtdwn && (t_ramp - t_run >= GRACE)) m_fault = 1;
          k = t - t_ramp;
          nd = (d0 == 0) ? 0 : d0 - (k / RAMP_DIV) * RAMP_STEP;
          if (nd < 0) nd = 0;
          m_duty = nd;
          if (nd == 0) begin m_en = 0; m_state = m_fault ? 3 : 0; t_clr = t; end
        end
        default: begin
          hold = t - 1 - t_clr;
          if (hold > REARM_HOLD) hold = REARM_HOLD;
          if (arm_rise && !run_req && hold == REARM_HOLD) begin m_state = 0; m_fault = 0; end
          else if (run_req) t_clr = t;
        end
      endcase
      if (f_before == 0 && m_fault == 1 && m_fcnt < 255) m_fcnt++;
      arm_prev = arm_req;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_1khz) begin
    if (cmp_on) begin
      chk("model_duty",  32'(duty_out),  32'(m_duty));
      chk("model_en",    32'(motor_en),  32'(m_en));
      chk("model_fault", 32'(fault),     32'(m_fault));
      chk("model_state", 32'(state_out), 32'(m_state));
`ifdef FAULT_COUNT_EN
      chk("model_fcnt",  32'(fault_cnt), 32'(m_fcnt));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1khz);
      #2;
    end
  endtask

  task automatic chk_out(input string name, input int d, input int en, input int f, input int s);
    chk({name, "_duty"},  32'(duty_out),  32'(d));
    chk({name, "_en"},    32'(motor_en),  32'(en));
    chk({name, "_fault"}, 32'(fault),     32'(f));
    chk({name, "_state"}, 32'(state_out), 32'(s));
  endtask

  initial begin
    int mode, len, r;
    // Reset held with run and watchdog asserted
    rst = 1'b1; run_req = 1'b1; wd_shtdwn = 1'b1; speed_cmd = 8'd32;
    for (int i = 0; i < 3; i++) begin
      step(1);
      cmp_on = 1'b1;
      chk_out("reset", 0, 0, 0, 0);
    end
    rst = 1'b0;
    step(1);
    chk_out("run_entry", 0, 1, 0, 1);
    // Watchdog held from RUN entry: ignored through grace
    for (int k = 1; k <= GRACE; k++) begin
      step(1);
      chk("grace_state", 32'(state_out), 32'd1);
      chk("grace_fault", 32'(fault), 32'd0);
    end
    step(1);
    chk_out("trip", 32, 1, 1, 2);
    wd_shtdwn = 1'b0; run_req = 1'b0;
    step(4);  chk("trip_e4",  32'(duty_out), 32'd24);
    step(4);  chk("trip_e8",  32'(duty_out), 32'd16);
    step(4);  chk("trip_e12", 32'(duty_out), 32'd8);
    step(4);  chk_out("trip_e16", 0, 0, 1, 3);
`ifdef FAULT_COUNT_EN
    chk("fcnt_one", 32'(fault_cnt), 32'd1);
`endif
    // Early re-arm ignored, late re-arm accepted
    step(5); arm_req = 1'b1;
    step(1); chk_out("early_arm", 0, 0, 1, 3); arm_req = 1'b0;
    step(10); arm_req = 1'b1;
    step(1); chk_out("rearm", 0, 0, 0, 0); arm_req = 1'b0;
    // Normal stop
    run_req = 1'b1; speed_cmd = 8'd32;
    step(1); chk_out("ns_entry", 0, 1, 0, 1);
    step(1); chk_out("ns_lag", 32, 1, 0, 1);
    run_req = 1'b0;
    step(1); chk_out("ns_ramp", 32, 1, 0, 2);
    step(4);  chk("ns_e4",  32'(duty_out), 32'd24);
    step(4);  chk("ns_e8",  32'(duty_out), 32'd16);
    step(4);  chk("ns_e12", 32'(duty_out), 32'd8);
    step(4);  chk_out("ns_e16", 0, 0, 0, 0);
    // Trip and stop in the same cycle, then reset mid-ramp
    run_req = 1'b1;
    step(1 + GRACE);
    wd_shtdwn = 1'b1; run_req = 1'b0;
    step(1); chk_out("both", 32, 1, 1, 2);
    wd_shtdwn = 1'b0;
    step(5); rst = 1'b1;
    step(1); chk_out("mid_rst", 0, 0, 0, 0);
`ifdef FAULT_COUNT_EN
    chk("fcnt_rst", 32'(fault_cnt), 32'd0);
`endif
    rst = 1'b0;
    // Re-arm refused while run_req is held high
    run_req = 1'b1;
    step(1 + GRACE);
    wd_shtdwn = 1'b1;
    step(1); wd_shtdwn = 1'b0;
    step(16); chk_out("hold_fault", 0, 0, 1, 3);
    for (int i = 0; i < 30; i++) begin
      arm_req = ~arm_req;
      step(1);
    end
    chk_out("run_held_arm", 0, 0, 1, 3);
    arm_req = 1'b0;
    // Randomized segments, checked every cycle by the model
    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 3);
      len = $urandom_range(100, 400);
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 99);
        case (mode)
          0: begin run_req = 1'b1; wd_shtdwn = (r < 2); end
          1: begin run_req = ($urandom_range(0, 99) >= 3); wd_shtdwn = (r < 1); end
          2: begin run_req = (r < 10); wd_shtdwn = ($urandom_range(0, 1) == 1); end
          default: begin run_req = (r < 50); wd_shtdwn = ($urandom_range(0, 1) == 1); end
        endcase
        arm_req = ($urandom_range(0, 99) < 40);
        if ($urandom_range(0, 99) < 5) speed_cmd = ($urandom_range(0, 9) == 0) ? '0 : DUTY_W'($urandom_range(0, 255));
        rst = ($urandom_range(0, 999) == 0);
        step(1);
      end
    end
    rst = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
